// File: rtl/bexkat_vtiming.sv
// Raster timing for the bexkat video generator: pixel strobe, line/frame counters, sync flags.
// Define BEXKAT_VTIMING_FRAMECNT_EN to add the frame_start / frame_cnt outputs.
module bexkat_vtiming (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pal,
    input  logic        scandouble,
    output logic        ce_pix,
    output logic [8:0]  hcount,
    output logic [8:0]  vcount,
    output logic        HBlank,
    output logic        HSync,
    output logic        VBlank,
    output logic        VSync
`ifdef BEXKAT_VTIMING_FRAMECNT_EN
    ,
    output logic        frame_start,
    output logic [15:0] frame_cnt
`endif
);

    logic [2:0] div_q;
    logic [2:0] div_nxt;
    logic [2:0] div_last;
    logic [9:0] line_q;
    logic [9:0] line_nxt;
    logic [9:0] line_last;
    logic [8:0] h_nxt;
    logic [8:0] v_nxt;
    logic       pal_q;
    logic       pal_nxt;
    logic       sd_q;
    logic       sd_nxt;
    logic       line_end;
    logic       frame_end;
    logic       hb_nxt;
    logic       hs_nxt;
    logic       vb_nxt;
    logic       vs_nxt;

    // Doubled mode halves the divider and doubles the line count,
    // so the frame period is the same in both scan modes.
    always_comb begin
        div_last  = sd_q ? 3'd3 : 3'd7;
        div_nxt   = (div_q == div_last) ? 3'd0 : div_q + 3'd1;
        if (pal_q)
            line_last = sd_q ? 10'd623 : 10'd311;
        else
            line_last = sd_q ? 10'd523 : 10'd261;
        line_end  = (hcount == 9'd383);
        frame_end = line_end && (line_q == line_last);
    end

    always_comb begin
        h_nxt    = hcount;
        line_nxt = line_q;
        pal_nxt  = pal_q;
        sd_nxt   = sd_q;
        if (ce_pix) begin
            h_nxt = line_end ? 9'd0 : hcount + 9'd1;
            if (line_end)
                line_nxt = frame_end ? 10'd0 : line_q + 10'd1;
            if (frame_end) begin
                pal_nxt = pal;
                sd_nxt  = scandouble;
            end
        end
        v_nxt = sd_nxt ? line_nxt[9:1] : line_nxt[8:0];
    end

    always_comb begin
        hb_nxt = (h_nxt >= 9'd320);
        hs_nxt = (h_nxt >= 9'd336) && (h_nxt <= 9'd367);
        vb_nxt = (v_nxt >= 9'd240);
        if (pal_nxt)
            vs_nxt = (v_nxt >= 9'd270) && (v_nxt <= 9'd272);
        else
            vs_nxt = (v_nxt >= 9'd244) && (v_nxt <= 9'd246);
    end

    assign vcount = sd_q ? line_q[9:1] : line_q[8:0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= 3'd0;
            ce_pix <= 1'b0;
            hcount <= 9'd0;
            line_q <= 10'd0;
            pal_q  <= 1'b0;
            sd_q   <= 1'b0;
            HBlank <= 1'b0;
            HSync  <= 1'b0;
            VBlank <= 1'b0;
            VSync  <= 1'b0;
        end else begin
            div_q  <= div_nxt;
            ce_pix <= (div_q == div_last);
            hcount <= h_nxt;
            line_q <= line_nxt;
            pal_q  <= pal_nxt;
            sd_q   <= sd_nxt;
            if (ce_pix) begin
                HBlank <= hb_nxt;
                HSync  <= hs_nxt;
                VBlank <= vb_nxt;
                VSync  <= vs_nxt;
            end
        end
    end

`ifdef BEXKAT_VTIMING_FRAMECNT_EN
    logic [15:0] fc_nxt;

    assign fc_nxt = (ce_pix && frame_end) ? frame_cnt + 16'd1 : frame_cnt;

    // frame_start is raised on the same edge as the wrapping ce_pix
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_start <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            frame_start <= (div_q == div_last) && frame_end;
            frame_cnt   <= fc_nxt;
        end
    end
`endif

endmodule
